hazard_ctrl: RTL and testbench

//   Hazard and forwarding controller for the 5-stage core. Produces flush/stall for the F/D, D/E
//   and E/M stage registers and operand-forward selects for the E-stage ALU, from D/E/M/W tags.

---
 rtl/hazard_ctrl_if.sv | 51 +++++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: D/E/M/W tags and dmem handshake in,
// stall/flush/forward controls and performance counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       ra1_d;
    logic [4:0]       ra2_d;
    logic [4:0]       ra1_e;
    logic [4:0]       ra2_e;
    logic [4:0]       wa_e;
    logic             regfile_we_e;
    logic [1:0]       regfile_src_sel_e;
    logic             jump_e;
    logic             branch_e;
    logic             branch_taken_e;
    logic [4:0]       wa_m;
    logic [4:0]       wa_w;
    logic             regfile_we_m;
    logic             regfile_we_w;
    logic             dmem_req_m;
    logic             dmem_ready;
    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies tags and handshake, consumes controls.
    modport master (
        output ra1_d, ra2_d, ra1_e, ra2_e, wa_e, regfile_we_e, regfile_src_sel_e,
               jump_e, branch_e, branch_taken_e, wa_m, wa_w, regfile_we_m,
               regfile_we_w, dmem_req_m, dmem_ready,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_a_sel, fwd_b_sel, bus_err, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  ra1_d, ra2_d, ra1_e, ra2_e, wa_e, regfile_we_e, regfile_src_sel_e,
               jump_e, branch_e, branch_taken_e, wa_m, wa_w, regfile_we_m,
               regfile_we_w, dmem_req_m, dmem_ready,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
               fwd_a_sel, fwd_b_sel, bus_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: operand forwarding,
// load-use bubble, redirect flush, dmem wait FSM with timeout, and
// saturating stall/flush counters. State advances on the falling clock edge.
module hazard_ctrl #(
    parameter logic [1:0]  LOAD_SEL = 2'b01,
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned WCNT_W =
        ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic load_use;
    logic redirect;
    logic stall_all;
    logic redir_flush;
    logic bubble;
    logic stall_fd;

    // Forward select for one E-stage source operand; M has priority, x0 never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] ra);
        logic [1:0] sel;
        sel = 2'b00;
        if (bus.regfile_we_m && bus.wa_m != 5'd0 && bus.wa_m == ra) begin
            sel = 2'b10;
        end else if (bus.regfile_we_w && bus.wa_w != 5'd0 && bus.wa_w == ra) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Hazard detection terms from the E-stage instruction.
    always_comb begin
        load_use = bus.regfile_we_e && (bus.regfile_src_sel_e == LOAD_SEL) &&
                   (bus.wa_e != 5'd0) &&
                   ((bus.wa_e == bus.ra1_d) || (bus.wa_e == bus.ra2_d));
        redirect = bus.jump_e || (bus.branch_e && bus.branch_taken_e);
    end

    // Next-state logic and per-state control decisions.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        stall_all   = 1'b0;
        redir_flush = 1'b0;
        bubble      = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (bus.dmem_req_m && !bus.dmem_ready) begin
                    stall_all = 1'b1;
                    state_d   = S_MEM_WAIT;
                    wcnt_d    = '0;
                end else if (redirect) begin
                    redir_flush = 1'b1;
                end else if (load_use) begin
                    bubble = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                stall_all = 1'b1;
                if (bus.dmem_ready) begin
                    state_d = S_RUN;
                end else if (wcnt_q == WCNT_W'(MAX_WAIT)) begin
                    state_d = S_ERR;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_ERR: begin
                stall_all = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Output drive; reset forces both flushes and masks stalls and forwarding.
    always_comb begin
        stall_fd      = stall_all || bubble;
        bus.stall_f   = !rst && stall_fd;
        bus.stall_d   = !rst && stall_fd;
        bus.stall_e   = !rst && stall_all;
        bus.stall_m   = !rst && stall_all;
        bus.flush_d   = rst || redir_flush;
        bus.flush_e   = rst || redir_flush || bubble;
        bus.fwd_a_sel = rst ? 2'b00 : fwd_sel(bus.ra1_e);
        bus.fwd_b_sel = rst ? 2'b00 : fwd_sel(bus.ra2_e);
        bus.bus_err   = (state_q == S_ERR);
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    // FSM state and wait counter.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Saturating performance counters.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_fd && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redir_flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned MAX_WAIT = 4;
    localparam longint      SAT      = (64'd1 << CNT_W) - 1;

    logic clk;
    logic rst;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(
        .LOAD_SEL(2'b01),
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe;
        logic [1:0] fa, fb;
        logic       be;
        logic       counts_flush;
    } exp_t;

    bit     m_waiting;
    bit     m_dead;
    int     m_wait_cycles;
    longint m_stalls;
    longint m_flushes;

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (bus.regfile_we_m && bus.wa_m == r) return 2'b10;
        if (bus.regfile_we_w && bus.wa_w == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        bit lu, redir, mem_hold;
        e = '0;
        if (rst) begin
            e.fd = 1'b1;
            e.fe = 1'b1;
            return e;
        end
        e.fa     = m_fwd(bus.ra1_e);
        e.fb     = m_fwd(bus.ra2_e);
        e.be     = m_dead;
        lu       = bus.regfile_we_e && bus.regfile_src_sel_e == 2'b01 && bus.wa_e != 0 &&
                   (bus.wa_e == bus.ra1_d || bus.wa_e == bus.ra2_d);
        redir    = bus.jump_e || (bus.branch_e && bus.branch_taken_e);
        mem_hold = m_dead || m_waiting || (bus.dmem_req_m && !bus.dmem_ready);
        if (mem_hold) begin
            {e.sf, e.sd, e.se, e.sm} = 4'b1111;
        end else if (redir) begin
            e.fd = 1'b1;
            e.fe = 1'b1;
            e.counts_flush = 1'b1;
        end else if (lu) begin
            e.sf = 1'b1;
            e.sd = 1'b1;
            e.fe = 1'b1;
        end
        return e;
    endfunction

    always @(posedge rst or negedge clk) begin
        exp_t e;
        if (rst) begin
            m_waiting     = 0;
            m_dead        = 0;
            m_wait_cycles = 0;
            m_stalls      = 0;
            m_flushes     = 0;
        end else begin
            e = expect_now();
            if (e.sf) m_stalls = (m_stalls + 1 > SAT) ? SAT : m_stalls + 1;
            if (e.counts_flush) m_flushes = (m_flushes + 1 > SAT) ? SAT : m_flushes + 1;
            if (!m_dead) begin
                if (m_waiting) begin
                    if (bus.dmem_ready) begin
                        m_waiting = 0;
                    end else begin
                        m_wait_cycles++;
                        if (m_wait_cycles > int'(MAX_WAIT)) begin
                            m_dead    = 1;
                            m_waiting = 0;
                        end
                    end
                end else if (bus.dmem_req_m && !bus.dmem_ready) begin
                    m_waiting     = 1;
                    m_wait_cycles = 0;
                end
            end
        end
    end

    // Compare process: every cycle, just before the state-updating edge.
    always @(posedge clk) begin
        exp_t e;
        #4;
        e = expect_now();
        check("stall_f",   64'(bus.stall_f),   64'(e.sf));
        check("stall_d",   64'(bus.stall_d),   64'(e.sd));
        check("stall_e",   64'(bus.stall_e),   64'(e.se));
        check("stall_m",   64'(bus.stall_m),   64'(e.sm));
        check("flush_d",   64'(bus.flush_d),   64'(e.fd));
        check("flush_e",   64'(bus.flush_e),   64'(e.fe));
        check("fwd_a_sel", 64'(bus.fwd_a_sel), 64'(e.fa));
        check("fwd_b_sel", 64'(bus.fwd_b_sel), 64'(e.fb));
        check("bus_err",   64'(bus.bus_err),   64'(e.be));
        check("stall_cnt", 64'(bus.stall_cnt), 64'(m_stalls));
        check("flush_cnt", 64'(bus.flush_cnt), 64'(m_flushes));
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        bus.ra1_d = 0; bus.ra2_d = 0; bus.ra1_e = 0; bus.ra2_e = 0; bus.wa_e = 0;
        bus.regfile_we_e = 0; bus.regfile_src_sel_e = 0; bus.jump_e = 0;
        bus.branch_e = 0; bus.branch_taken_e = 0; bus.wa_m = 0; bus.wa_w = 0;
        bus.regfile_we_m = 0; bus.regfile_we_w = 0; bus.dmem_req_m = 0; bus.dmem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #2;
    endtask

    task automatic set_load_use();
        bus.regfile_we_e = 1; bus.regfile_src_sel_e = 2'b01; bus.wa_e = 6;
        bus.ra1_d = 6; bus.ra2_d = 1;
    endtask

    int ready_pct;

    initial begin
        rst = 1'b1;
        clr();
        tick(); probe();
        check("rst_flush_d",   64'(bus.flush_d),   1);
        check("rst_flush_e",   64'(bus.flush_e),   1);
        check("rst_stall_f",   64'(bus.stall_f),   0);
        check("rst_stall_cnt", 64'(bus.stall_cnt), 0);
        check("rst_bus_err",   64'(bus.bus_err),   0);
        tick(); rst = 1'b0;

        // Forwarding
        bus.regfile_we_m = 1; bus.wa_m = 5; bus.ra1_e = 5; probe();
        check("fwd_from_m", 64'(bus.fwd_a_sel), 2);
        tick(); clr(); bus.regfile_we_w = 1; bus.wa_w = 5; bus.ra1_e = 5; probe();
        check("fwd_from_w", 64'(bus.fwd_a_sel), 1);
        tick(); clr(); bus.regfile_we_m = 1; bus.regfile_we_w = 1; probe();
        check("fwd_x0", 64'(bus.fwd_a_sel), 0);
        tick(); clr(); bus.regfile_we_m = 1; bus.wa_m = 7; bus.regfile_we_w = 1; bus.wa_w = 7;
        bus.ra2_e = 7; probe();
        check("fwd_m_over_w", 64'(bus.fwd_b_sel), 2);

        // Load-use bubble, then forward from M
        tick(); clr(); set_load_use(); probe();
        check("lu_stall_f", 64'(bus.stall_f), 1);
        check("lu_stall_d", 64'(bus.stall_d), 1);
        check("lu_flush_e", 64'(bus.flush_e), 1);
        check("lu_flush_d", 64'(bus.flush_d), 0);
        check("lu_stall_e", 64'(bus.stall_e), 0);
        tick(); clr(); bus.ra1_d = 6; bus.ra2_d = 1; bus.regfile_we_m = 1; bus.wa_m = 6;
        bus.ra1_e = 6; probe();
        check("lu_after_stall_f", 64'(bus.stall_f), 0);
        check("lu_after_fwd",     64'(bus.fwd_a_sel), 2);

        // Redirect overrides load-use
        tick(); clr(); set_load_use(); bus.branch_e = 1; bus.branch_taken_e = 1; probe();
        check("br_flush_d",   64'(bus.flush_d),   1);
        check("br_flush_e",   64'(bus.flush_e),   1);
        check("br_stall_f",   64'(bus.stall_f),   0);
        check("br_cnt_before", 64'(bus.flush_cnt), 0);
        tick(); clr(); probe();
        check("br_cnt_after", 64'(bus.flush_cnt), 1);

        // dmem wait: ready low 3 cycles then high
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; bus.dmem_req_m = 1; bus.dmem_ready = 0; probe();
        check("mw_c0_stall", 64'(bus.stall_f), 1);
        tick(); probe(); check("mw_c1_stall", 64'(bus.stall_m), 1);
        tick(); probe(); check("mw_c2_stall", 64'(bus.stall_e), 1);
        tick(); bus.dmem_ready = 1; probe(); check("mw_c3_stall", 64'(bus.stall_f), 1);
        tick(); clr(); probe();
        check("mw_done_stall", 64'(bus.stall_f),   0);
        check("mw_stall_cnt",  64'(bus.stall_cnt), 4);

        // Timeout into ERR
        tick(); bus.dmem_req_m = 1; bus.dmem_ready = 0;
        for (int k = 1; k <= 5; k++) begin
            tick(); probe();
            check("to_wait_no_err", 64'(bus.bus_err), 0);
        end
        tick(); probe();
        check("to_bus_err", 64'(bus.bus_err), 1);
        check("to_stall_m", 64'(bus.stall_m), 1);
        clr();
        for (int k = 0; k < 20; k++) tick();
        probe();
        check("err_sticky",   64'(bus.bus_err),   1);
        check("err_stall_f",  64'(bus.stall_f),   1);
        check("err_cnt_sat",  64'(bus.stall_cnt), 15);
        tick(); rst = 1'b1; probe();
        check("err_rst_be",  64'(bus.bus_err),   0);
        check("err_rst_cnt", 64'(bus.stall_cnt), 0);
        tick(); rst = 1'b0; probe();
        check("err_cleared_stall", 64'(bus.stall_f), 0);

        // Reset in the middle of a wait
        tick(); bus.dmem_req_m = 1; bus.dmem_ready = 0;
        tick(); probe(); check("rmw_waiting", 64'(bus.stall_f), 1);
        tick(); rst = 1'b1; probe();
        check("rmw_flush_d", 64'(bus.flush_d),   1);
        check("rmw_flush_e", 64'(bus.flush_e),   1);
        check("rmw_stall_f", 64'(bus.stall_f),   0);
        check("rmw_cnt",     64'(bus.stall_cnt), 0);
        tick(); rst = 1'b0; clr(); probe();
        check("rmw_run", 64'(bus.stall_f), 0);

        // Ready in the request's first cycle: no stall
        tick(); bus.dmem_req_m = 1; bus.dmem_ready = 1; probe();
        check("fast_ready_stall", 64'(bus.stall_f), 0);
        tick(); clr(); probe();
        check("fast_ready_run", 64'(bus.stall_e), 0);

        // Randomized traffic
        ready_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                case ($urandom_range(0, 2))
                    0: ready_pct = 30;
                    1: ready_pct = 75;
                    default: ready_pct = 95;
                endcase
            end
            bus.ra1_d = 5'($urandom_range(0, 3));
            bus.ra2_d = 5'($urandom_range(0, 3));
            bus.ra1_e = 5'($urandom_range(0, 3));
            bus.ra2_e = 5'($urandom_range(0, 3));
            bus.wa_e  = 5'($urandom_range(0, 3));
            bus.wa_m  = 5'($urandom_range(0, 3));
            bus.wa_w  = 5'($urandom_range(0, 3));
            bus.regfile_we_e = 1'($urandom_range(0, 1));
            bus.regfile_we_m = 1'($urandom_range(0, 1));
            bus.regfile_we_w = 1'($urandom_range(0, 1));
            bus.regfile_src_sel_e = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            bus.jump_e = ($urandom_range(0, 99) < 10);
            bus.branch_e = ($urandom_range(0, 99) < 25);
            bus.branch_taken_e = 1'($urandom_range(0, 1));
            bus.dmem_req_m = ($urandom_range(0, 99) < 30);
            bus.dmem_ready = ($urandom_range(0, 99) < ready_pct);
        end
        tick(); rst = 1'b0; clr();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
